// File: rtl/melody_seq_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | melody_seq_if : note-table write port, playback control and status.  |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
interface melody_seq_if;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [2:0] wr_tone;
    logic [3:0] wr_len;
    logic       start;
    logic       stop;
    logic       loop;
    logic [2:0] tone;
    logic       tone_en;
    logic       busy;
    logic [3:0] note_idx;
    logic       done;

    modport master (
        output wr_en, wr_addr, wr_tone, wr_len, start, stop, loop,
        input  tone, tone_en, busy, note_idx, done
    );

    modport slave (
        input  wr_en, wr_addr, wr_tone, wr_len, start, stop, loop,
        output tone, tone_en, busy, note_idx, done
    );
endinterface
`default_nettype wire

// File: rtl/melody_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | melody_seq : 16-entry note table player driving a tone generator.    |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
module melody_seq #(
    parameter int unsigned BEAT_DIV   = 12500000,
    parameter int unsigned GAP_CYCLES = 2500000
) (
    input  wire logic  clk_i,
    input  wire logic  reset_i,
    melody_seq_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_NOTE  = 2'd2,
        S_GAP   = 2'd3
    } state_t;

    localparam logic [31:0] C_BEAT_LAST = 32'(BEAT_DIV - 1);
    localparam logic [31:0] C_GAP_LAST  = (GAP_CYCLES == 0) ? 32'd0 : 32'(GAP_CYCLES - 1);

    state_t      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [2:0]  tone_q, tone_d;
    logic        tone_en_q, tone_en_d;
    logic        done_q, done_d;
    logic [31:0] beat_q, beat_d;
    logic [31:0] gap_q, gap_d;
    logic [3:0]  left_q, left_d;
    logic [6:0]  note_tbl_q [16];

    logic [6:0]  w_entry;
    logic [3:0]  w_first_len;
    logic        w_advance;
    logic        w_eos;

    assign w_entry     = note_tbl_q[idx_q];
    assign w_first_len = note_tbl_q[0][3:0];

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < 16; i++) begin
                note_tbl_q[i] <= 7'd0;
            end
        end else if (bus.wr_en && (state_q == S_IDLE)) begin
            note_tbl_q[bus.wr_addr] <= {bus.wr_tone, bus.wr_len};
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= S_IDLE;
            idx_q     <= 4'd0;
            tone_q    <= 3'd0;
            tone_en_q <= 1'b0;
            done_q    <= 1'b0;
            beat_q    <= 32'd0;
            gap_q     <= 32'd0;
            left_q    <= 4'd0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            tone_q    <= tone_d;
            tone_en_q <= tone_en_d;
            done_q    <= done_d;
            beat_q    <= beat_d;
            gap_q     <= gap_d;
            left_q    <= left_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        tone_d    = tone_q;
        tone_en_d = tone_en_q;
        done_d    = 1'b0;
        beat_d    = beat_q;
        gap_d     = gap_q;
        left_d    = left_q;
        w_advance = 1'b0;
        w_eos     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start && !bus.stop) begin
                    state_d = S_FETCH;
                    idx_d   = 4'd0;
                end
            end
            S_FETCH: begin
                if (w_entry[3:0] != 4'd0) begin
                    state_d   = S_NOTE;
                    tone_d    = w_entry[6:4];
                    tone_en_d = 1'b1;
                    left_d    = w_entry[3:0];
                    beat_d    = 32'd0;
                end else begin
                    w_eos = 1'b1;
                end
            end
            S_NOTE: begin
                if (beat_q == C_BEAT_LAST) begin
                    beat_d = 32'd0;
                    left_d = left_q - 4'd1;
                    if (left_q == 4'd1) begin
                        tone_en_d = 1'b0;
                        if (GAP_CYCLES == 0) begin
                            w_advance = 1'b1;
                        end else begin
                            state_d = S_GAP;
                            gap_d   = 32'd0;
                        end
                    end
                end else begin
                    beat_d = beat_q + 32'd1;
                end
            end
            S_GAP: begin
                if (gap_q == C_GAP_LAST) begin
                    gap_d     = 32'd0;
                    w_advance = 1'b1;
                end else begin
                    gap_d = gap_q + 32'd1;
                end
            end
        endcase

        if (w_advance) begin
            if (idx_q == 4'd15) begin
                w_eos = 1'b1;
            end else begin
                state_d = S_FETCH;
                idx_d   = idx_q + 4'd1;
            end
        end

        // Looping on an empty first entry would spin forever, so it ends the song instead.
        if (w_eos) begin
            if (bus.loop && (w_first_len != 4'd0)) begin
                state_d = S_FETCH;
                idx_d   = 4'd0;
            end else begin
                state_d   = S_IDLE;
                done_d    = 1'b1;
                tone_en_d = 1'b0;
            end
        end

        if (bus.stop) begin
            state_d   = S_IDLE;
            tone_en_d = 1'b0;
            done_d    = 1'b0;
            beat_d    = 32'd0;
            gap_d     = 32'd0;
            left_d    = 4'd0;
        end
    end

    assign bus.tone     = tone_q;
    assign bus.tone_en  = tone_en_q;
    assign bus.busy     = (state_q != S_IDLE);
    assign bus.note_idx = idx_q;
    assign bus.done     = done_q;

endmodule
`default_nettype wire

// File: tb/tb_melody_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_melody_seq : directed bench for melody_seq, BEAT_DIV=4, GAP=2.    |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
module tb_melody_seq;

    logic clk_i;
    logic reset_i;
    int   n_vec;
    int   n_err;

    melody_seq_if bus ();

    melody_seq #(
        .BEAT_DIV   (4),
        .GAP_CYCLES (2)
    ) dut (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .bus     (bus.slave)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic write_entry(input int addr, input logic [2:0] t, input logic [3:0] len);
        bus.wr_en   = 1'b1;
        bus.wr_addr = 4'(addr);
        bus.wr_tone = t;
        bus.wr_len  = len;
        tick();
        bus.wr_en   = 1'b0;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        logic [11:0] obs;
        reset_i = 1'b1;
        #1;
        obs = {bus.busy, bus.tone_en, bus.done, bus.note_idx, bus.tone, 2'b00};
        n_vec++;
        if (obs !== 12'd0) begin
            n_err++;
            $display("FAIL reset_async obs=%h exp=%h", obs, 12'd0);
        end
        tick();
        reset_i = 1'b0;
        tick();
        obs = {bus.busy, bus.tone_en, bus.done, bus.note_idx, bus.tone, 2'b00};
        n_vec++;
        if (obs !== 12'd0) begin
            n_err++;
            $display("FAIL reset_release obs=%h exp=%h", obs, 12'd0);
        end
    endtask

    // {Do,2},{Mi,1},{x,0}: FETCH k0, Do k1..8, gap k9..10, FETCH k11, Mi k12..15,
    // gap k16..17, FETCH k18, done+IDLE k19.
    task automatic test_basic();
        logic [9:0] obs, exp;
        write_entry(0, 3'b000, 4'd2);
        write_entry(1, 3'b010, 4'd1);
        write_entry(2, 3'b111, 4'd0);
        pulse_start();
        for (int k = 0; k <= 21; k++) begin
            exp[9]   = (k <= 18);
            exp[8]   = ((k >= 1) && (k <= 8)) || ((k >= 12) && (k <= 15));
            exp[7]   = (k == 19);
            exp[6:3] = (k < 11) ? 4'd0 : ((k < 18) ? 4'd1 : 4'd2);
            exp[2:0] = (k >= 12) ? 3'b010 : 3'b000;
            obs = {bus.busy, bus.tone_en, bus.done, bus.note_idx, bus.tone};
            n_vec++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL basic k=%0d obs=%b exp=%b", k, obs, exp);
            end
            tick();
        end
    endtask

    // 16 x len=1: 7 cycles per entry (FETCH, 4 note, 2 gap); end of song at k=112.
    task automatic test_all16();
        logic [6:0] obs, exp;
        for (int i = 0; i < 16; i++) write_entry(i, 3'(i % 8), 4'd1);
        bus.loop = 1'b0;
        pulse_start();
        for (int k = 0; k <= 114; k++) begin
            exp[6]   = (k < 112);
            exp[5]   = (k < 112) && ((k % 7) >= 1) && ((k % 7) <= 4);
            exp[4]   = (k == 112);
            exp[3:0] = (k < 112) ? 4'(k / 7) : 4'd15;
            obs = {bus.busy, bus.tone_en, bus.done, bus.note_idx};
            n_vec++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL all16 k=%0d obs=%b exp=%b", k, obs, exp);
            end
            if (exp[5]) begin
                n_vec++;
                if (bus.tone !== 3'((k / 7) % 8)) begin
                    n_err++;
                    $display("FAIL all16_tone k=%0d obs=%0d exp=%0d", k, bus.tone, (k / 7) % 8);
                end
            end
            tick();
        end
    endtask

    task automatic test_loop_stop();
        logic [6:0] obs, exp;
        logic       saw_done;
        saw_done = 1'b0;
        bus.loop = 1'b1;
        pulse_start();
        for (int k = 0; k <= 114; k++) begin
            saw_done = saw_done | bus.done;
            if (k >= 110) begin
                exp[6]   = 1'b1;
                exp[5]   = (k == 113) || (k == 114);
                exp[4]   = 1'b0;
                exp[3:0] = (k < 112) ? 4'd15 : 4'd0;
                obs = {bus.busy, bus.tone_en, bus.done, bus.note_idx};
                n_vec++;
                if (obs !== exp) begin
                    n_err++;
                    $display("FAIL loop k=%0d obs=%b exp=%b", k, obs, exp);
                end
            end
            if (k < 114) tick();
        end
        n_vec++;
        if (saw_done !== 1'b0) begin
            n_err++;
            $display("FAIL loop_no_done obs=%b exp=0", saw_done);
        end
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        bus.loop = 1'b0;
        for (int k = 0; k < 3; k++) begin
            obs = {bus.busy, bus.tone_en, bus.done, 4'd0};
            n_vec++;
            if (obs !== 7'd0) begin
                n_err++;
                $display("FAIL stop k=%0d obs=%b exp=%b", k, obs, 7'd0);
            end
            tick();
        end
    endtask

    task automatic test_empty_loop();
        logic [2:0] obs, exp;
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        tick();
        bus.loop = 1'b1;
        pulse_start();
        for (int k = 0; k <= 3; k++) begin
            exp = {(k == 0), 1'b0, (k == 1)};
            obs = {bus.busy, bus.tone_en, bus.done};
            n_vec++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL empty_loop k=%0d obs=%b exp=%b", k, obs, exp);
            end
            tick();
        end
        bus.loop = 1'b0;
    endtask

    // Entry0 {Sol,1}, entry1 end marker; writes during playback must not stick.
    task automatic test_wr_busy();
        logic [7:0] obs, exp;
        int         waited;
        write_entry(0, 3'b100, 4'd1);
        pulse_start();
        tick();
        write_entry(0, 3'b001, 4'd2);
        write_entry(1, 3'b010, 4'd3);
        waited = 0;
        while (bus.busy && waited < 60) begin
            tick();
            waited++;
        end
        n_vec++;
        if (bus.busy !== 1'b0) begin
            n_err++;
            $display("FAIL wr_busy_timeout busy=%b exp=0", bus.busy);
        end
        tick();
        pulse_start();
        for (int k = 0; k <= 9; k++) begin
            exp[7]   = (k <= 7);
            exp[6]   = (k >= 1) && (k <= 4);
            exp[5]   = (k == 8);
            exp[4:3] = 2'b00;
            exp[2:0] = 3'b100;
            obs = {bus.busy, bus.tone_en, bus.done, 2'b00, bus.tone};
            if (k == 0) exp[2:0] = bus.tone;
            n_vec++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL wr_busy_replay k=%0d obs=%b exp=%b", k, obs, exp);
            end
            tick();
        end
    endtask

    task automatic test_start_stop();
        bus.start = 1'b1;
        bus.stop  = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        for (int k = 0; k < 3; k++) begin
            n_vec++;
            if (bus.busy !== 1'b0) begin
                n_err++;
                $display("FAIL start_stop k=%0d busy=%b exp=0", k, bus.busy);
            end
            tick();
        end
    endtask

    task automatic test_async_reset();
        logic [11:0] obs;
        logic [2:0]  o3, e3;
        write_entry(0, 3'b101, 4'd3);
        pulse_start();
        tick();
        tick();
        n_vec++;
        if ({bus.busy, bus.tone_en, bus.tone} !== 5'b11101) begin
            n_err++;
            $display("FAIL areset_pre obs=%b exp=%b", {bus.busy, bus.tone_en, bus.tone}, 5'b11101);
        end
        #2;
        reset_i = 1'b1;
        #1;
        obs = {bus.busy, bus.tone_en, bus.done, bus.note_idx, bus.tone, 2'b00};
        n_vec++;
        if (obs !== 12'd0) begin
            n_err++;
            $display("FAIL areset_now obs=%h exp=%h", obs, 12'd0);
        end
        #1;
        reset_i = 1'b0;
        tick();
        pulse_start();
        for (int k = 0; k <= 2; k++) begin
            e3 = {(k == 0), 1'b0, (k == 1)};
            o3 = {bus.busy, bus.tone_en, bus.done};
            n_vec++;
            if (o3 !== e3) begin
                n_err++;
                $display("FAIL areset_silent k=%0d obs=%b exp=%b", k, o3, e3);
            end
            tick();
        end
    endtask

    initial begin
        n_vec       = 0;
        n_err       = 0;
        bus.wr_en   = 1'b0;
        bus.wr_addr = 4'd0;
        bus.wr_tone = 3'd0;
        bus.wr_len  = 4'd0;
        bus.start   = 1'b0;
        bus.stop    = 1'b0;
        bus.loop    = 1'b0;
        reset_i     = 1'b0;
        test_reset();
        test_basic();
        test_all16();
        test_loop_stop();
        test_empty_loop();
        test_wr_busy();
        test_start_stop();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
